// File: rtl/core_pkg.sv
// Shared EX/MEM definitions: control bit positions, skid-buffer states, buffered entry layout.
// Entry widths are fixed by the constants below; ex_mem_stage parameters must match them.
package core_pkg;

    localparam int XLEN_DEF       = 32;
    localparam int REG_ADDR_W_DEF = 5;

    // Bit positions inside the 5-bit EX control word {reg_write, mem_read, mem_write, mem_to_reg, branch}
    localparam int CTRL_REG_WRITE  = 4;
    localparam int CTRL_MEM_READ   = 3;
    localparam int CTRL_MEM_WRITE  = 2;
    localparam int CTRL_MEM_TO_REG = 1;
    localparam int CTRL_BRANCH     = 0;

    typedef enum logic [1:0] {
        BUF_EMPTY = 2'd0,
        BUF_ONE   = 2'd1,
        BUF_FULL  = 2'd2
    } buf_state_e;

    typedef struct packed {
        logic [XLEN_DEF-1:0]       result;
        logic [XLEN_DEF-1:0]       store_data;
        logic [REG_ADDR_W_DEF-1:0] rd;
        logic [3:0]                ctrl;
    } exmem_entry_t;

    // Branches travel down the pipe as bubbles: no register, load or store side effects.
    function automatic logic [3:0] entry_ctrl(input logic [4:0] ctrl);
        if (ctrl[CTRL_BRANCH]) begin
            return {3'b000, ctrl[CTRL_MEM_TO_REG]};
        end
        return ctrl[4:1];
    endfunction

endpackage

// File: rtl/ex_mem_stage_if.sv
// EX->MEM bus: EX-side beat with its handshake, MEM-side head entry with its handshake.
// slave is the stage's view, master is the surrounding pipeline's view.
interface ex_mem_stage_if #(
    parameter int XLEN     = 32,
    parameter int RegAddrW = 5
);
    logic                ex_valid;
    logic                ex_ready;
    logic [XLEN-1:0]     alu_result;
    logic                alu_zero;
    logic [XLEN-1:0]     store_data;
    logic [XLEN-1:0]     branch_target;
    logic [RegAddrW-1:0] rd;
    logic [4:0]          ctrl;

    logic                mem_valid;
    logic                mem_ready;
    logic [XLEN-1:0]     mem_result;
    logic [XLEN-1:0]     mem_store_data;
    logic [RegAddrW-1:0] mem_rd;
    logic [3:0]          mem_ctrl;

    modport master (
        output ex_valid, alu_result, alu_zero, store_data, branch_target, rd, ctrl, mem_ready,
        input  ex_ready, mem_valid, mem_result, mem_store_data, mem_rd, mem_ctrl
    );

    modport slave (
        input  ex_valid, alu_result, alu_zero, store_data, branch_target, rd, ctrl, mem_ready,
        output ex_ready, mem_valid, mem_result, mem_store_data, mem_rd, mem_ctrl
    );
endinterface

// File: rtl/ex_mem_stage_skid_buf2.sv
// skid_buf2: generic 2-entry valid/ready buffer; flush empties it and drops a same-cycle push.
// Latency: 1 cycle into an empty or draining buffer. Backpressure: in_ready is registered (state != FULL).
module skid_buf2 import core_pkg::*; #(
    parameter type T = logic
) (
    input  logic clk,
    input  logic reset,
    input  logic flush,
    input  logic in_valid,
    output logic in_ready,
    input  T     in_data,
    output logic out_valid,
    input  logic out_ready,
    output T     out_data
);
    buf_state_e state_q, state_d;
    T           head_q, head_d;
    T           skid_q, skid_d;
    logic       in_ready_q, in_ready_d;
    logic       push, pop;

    assign out_valid = (state_q != BUF_EMPTY);
    assign out_data  = head_q;
    assign in_ready  = in_ready_q;
    assign push      = in_valid & in_ready_q & ~flush;
    assign pop       = out_valid & out_ready;

    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        skid_d  = skid_q;
        case (state_q)
            BUF_EMPTY: if (push) begin
                state_d = BUF_ONE;
                head_d  = in_data;
            end
            BUF_ONE: begin
                if (push && !pop) begin
                    state_d = BUF_FULL;
                    skid_d  = in_data;
                end else if (!push && pop) begin
                    state_d = BUF_EMPTY;
                end else if (push && pop) begin
                    head_d  = in_data;
                end
            end
            BUF_FULL: if (pop) begin
                state_d = BUF_ONE;
                head_d  = skid_q;
            end
            default: state_d = BUF_EMPTY;
        endcase
        if (flush) begin
            state_d = BUF_EMPTY;
        end
        in_ready_d = (state_d != BUF_FULL);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= BUF_EMPTY;
            head_q     <= '0;
            skid_q     <= '0;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            head_q     <= head_d;
            skid_q     <= skid_d;
            in_ready_q <= in_ready_d;
        end
    end

endmodule

// File: rtl/ex_mem_stage.sv
// EX->MEM stage: skid-buffered ALU results, branch resolution with wrong-path kill, MEM forwarding. Optional EXMEM_PERF_EN counters.
// Latency: 1 cycle when the buffer is empty or draining; branch_taken pulses the cycle after the branch is accepted.
// Backpressure: ex_ready is registered and drops only when both entries are occupied.
module ex_mem_stage import core_pkg::*; #(
    parameter int XLEN     = 32,
    parameter int RegAddrW = 5
) (
    input  logic                clk,
    input  logic                reset,
    ex_mem_stage_if.slave       bus,
    input  logic                flush,
    output logic                branch_taken,
    output logic [XLEN-1:0]     redirect_pc,
    output logic                fwd_en,
    output logic [RegAddrW-1:0] fwd_rd,
    output logic [XLEN-1:0]     fwd_data,
    output logic [31:0]         perf_stall_cnt,
    output logic [31:0]         perf_br_cnt
);
    exmem_entry_t    in_ent, head;
    logic            in_vld, in_rdy, out_vld, accept;
    logic            branch_taken_q, branch_taken_d;
    logic [XLEN-1:0] redirect_pc_q, redirect_pc_d;

    // The beat arriving while a redirect is out is on the wrong path; flush also drops it.
    assign in_vld = bus.ex_valid & ~branch_taken_q & ~flush;
    assign accept = in_vld & in_rdy;

    always_comb begin
        in_ent            = '0;
        in_ent.result     = bus.alu_result;
        in_ent.store_data = bus.store_data;
        in_ent.rd         = bus.rd;
        in_ent.ctrl       = entry_ctrl(bus.ctrl);
    end

    skid_buf2 #(.T(exmem_entry_t)) u_buf (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_vld),
        .in_ready  (in_rdy),
        .in_data   (in_ent),
        .out_valid (out_vld),
        .out_ready (bus.mem_ready),
        .out_data  (head)
    );

    assign bus.ex_ready       = in_rdy;
    assign bus.mem_valid      = out_vld;
    assign bus.mem_result     = head.result;
    assign bus.mem_store_data = head.store_data;
    assign bus.mem_rd         = head.rd;
    assign bus.mem_ctrl       = head.ctrl;

    always_comb begin
        branch_taken_d = accept & bus.ctrl[CTRL_BRANCH] & bus.alu_zero;
        redirect_pc_d  = redirect_pc_q;
        if (accept && bus.ctrl[CTRL_BRANCH]) begin
            redirect_pc_d = bus.branch_target;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            branch_taken_q <= 1'b0;
            redirect_pc_q  <= '0;
        end else begin
            branch_taken_q <= branch_taken_d;
            redirect_pc_q  <= redirect_pc_d;
        end
    end

    assign branch_taken = branch_taken_q;
    assign redirect_pc  = redirect_pc_q;
    assign fwd_en       = out_vld & head.ctrl[CTRL_REG_WRITE-1] & (head.rd != '0);
    assign fwd_rd       = head.rd;
    assign fwd_data     = head.result;

`ifdef EXMEM_PERF_EN
    logic [31:0] perf_stall_q, perf_stall_d;
    logic [31:0] perf_br_q, perf_br_d;

    always_comb begin
        perf_stall_d = perf_stall_q;
        perf_br_d    = perf_br_q;
        if (out_vld && !bus.mem_ready) begin
            perf_stall_d = perf_stall_q + 32'd1;
        end
        if (branch_taken_q) begin
            perf_br_d = perf_br_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_stall_q <= '0;
            perf_br_q    <= '0;
        end else begin
            perf_stall_q <= perf_stall_d;
            perf_br_q    <= perf_br_d;
        end
    end

    assign perf_stall_cnt = perf_stall_q;
    assign perf_br_cnt    = perf_br_q;
`else
    assign perf_stall_cnt = '0;
    assign perf_br_cnt    = '0;
`endif

endmodule

// File: doc/ex_mem_stage.md
# ex_mem_stage

EX→MEM pipeline stage of the pipelined RISC-V core: accepts one ALU result per cycle from the EX-stage ALU together with its control bits, buffers it in a 2-entry skid buffer, and presents it to the data-memory stage with a valid/ready handshake. It also resolves conditional branches from the ALU zero flag and drives the EX-stage forwarding path from its head entry.

## Interface
Parameters:
- XLEN, 32, datapath width (result, store data, branch target)
- RegAddrW, 5, register index width

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- ex_valid  in  1  EX beat present
- ex_ready  out  1  stage can accept a beat; registered, never combinational from mem_ready
- alu_result  in  XLEN  ALU Result
- alu_zero  in  1  ALU zero flag
- store_data  in  XLEN  rs2 value for stores
- branch_target  in  XLEN  PC+imm computed in EX
- rd  in  RegAddrW  destination register
- ctrl  in  5  {reg_write, mem_read, mem_write, mem_to_reg, branch}
- flush  in  1  trap flush: discard all buffered entries
- mem_valid  out  1  head entry valid
- mem_ready  in  1  memory stage accepts head
- mem_result, mem_store_data  out  XLEN  head fields
- mem_rd  out  RegAddrW  head rd
- mem_ctrl  out  4  head {reg_write, mem_read, mem_write, mem_to_reg}
- branch_taken  out  1  one-cycle redirect pulse
- redirect_pc  out  XLEN  target, valid while branch_taken=1
- fwd_en  out  1  mem_valid & mem_ctrl.reg_write & (mem_rd != 0)
- fwd_rd  out  RegAddrW  = mem_rd
- fwd_data  out  XLEN  = mem_result
- perf_stall_cnt, perf_br_cnt  out  32  performance counters

## Operation
- Accept when ex_valid & ex_ready; transfer out when mem_valid & mem_ready.
- Buffer states: EMPTY (0 entries), ONE, FULL (2). ex_ready = (state != FULL), registered.
- EMPTY: accept → ONE. ONE: accept without transfer → FULL; transfer without accept → EMPTY; both → ONE (new entry becomes head next cycle). FULL: transfer → ONE (skid entry moves to head); no accept possible.
- Branch: on accepting a beat with ctrl.branch=1, branch_taken=alu_zero is registered, and redirect_pc is loaded with branch_target. Branch beats enter the buffer with reg_write=mem_read=mem_write=0 (pass through as bubbles).
- Kill window: in the cycle branch_taken=1, an accepted beat is discarded (wrong-path instruction); ex_ready stays as defined. Upstream flushes IF/ID itself.
- flush=1: next state EMPTY, mem_valid=0, branch_taken=0; an accept in the same cycle is discarded. flush has priority over everything.
- Head fields hold stable while mem_valid & !mem_ready.

## Timing
- Reset values: state EMPTY, mem_valid 0, ex_ready 1, branch_taken 0, redirect_pc 0, all mem_* and fwd_* 0, counters 0.
- Latency: beat accepted in cycle t is on mem_* in t+1 when the buffer was EMPTY or transferring.
- Throughput: 1 beat/cycle while mem_ready=1.
- branch_taken: exactly one cycle, in t+1 after the branch beat is accepted.
- Reset mid-operation clears buffer contents immediately (async); no partial beat survives.

## Configuration
- EXMEM_PERF_EN defined: perf_stall_cnt increments each cycle with mem_valid & !mem_ready; perf_br_cnt increments on each branch_taken pulse; both wrap at 2^32, cleared by reset only.
- Not defined: both ports tied to 0, no counter flops.

## Structure
- Shared package core_pkg: ctrl bit index constants, buffer-state enum (EMPTY/ONE/FULL), exmem_entry_t struct {result, store_data, rd, ctrl}.
- One sub-module: skid_buf2, generic 2-entry valid/ready buffer parameterised on the entry type; ex_mem_stage adds branch, kill, flush, forwarding, counters.

## Test plan
- Stream 4 beats, mem_ready=1: mem_result appears 1 cycle after each accept, ex_ready stays 1, no gaps.
- Hold mem_ready=0, send 3 beats: first two accepted, ex_ready=0 after second; release → order A, B, then C accepted; perf_stall_cnt equals stalled cycles (EXMEM_PERF_EN).
- Branch beat alu_zero=1, branch_target=0x0000_0040: next cycle branch_taken=1, redirect_pc=0x40; beat accepted that cycle never reaches mem_valid.
- Branch with alu_zero=0: branch_taken stays 0; following beat passes normally.
- FULL buffer, assert flush with ex_valid=1: next cycle mem_valid=0, ex_ready=1, nothing from before flush emerges.
- Head rd=0, reg_write=1: fwd_en=0; rd=5, result=0xDEAD_BEEF: fwd_en=1, fwd_data=0xDEAD_BEEF; async reset mid-stream clears all outputs immediately.
